// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage ARM pipeline: E-stage forwarding selects,
// load-use / PC-write / branch stall and flush controls, and perf counters.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             BranchD,
  input  logic             CondExE,
  input  logic             PerfClear,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BranchTakenE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdW   = 2'b01;
  localparam logic [1:0] FwdM   = 2'b10;
  localparam logic [3:0] RegPc  = 4'hF;

  // D-stage valid flag and the D inputs qualified by it
  logic       valid_d_q, valid_d_d;
  logic [3:0] ra1_dg, ra2_dg, wa3_dg;
  logic       reg_write_dg, mem_to_reg_dg, pc_src_dg, branch_dg;

  // E-stage shadow registers
  logic [3:0] ra1_e_q, ra2_e_q, wa3_e_q;
  logic       reg_write_e_q, mem_to_reg_e_q, pc_src_e_q, branch_e_q;

  // M- and W-stage shadow registers
  logic [3:0] wa3_m_q, wa3_w_q;
  logic       reg_write_m_q, pc_src_m_q;
  logic       reg_write_w_q, pc_src_w_q;

  // Hazard terms
  logic       ldr_stall;
  logic       pc_wr_pending;

  // Performance counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    ra1_dg        = valid_d_q ? RA1D : 4'h0;
    ra2_dg        = valid_d_q ? RA2D : 4'h0;
    wa3_dg        = valid_d_q ? WA3D : 4'h0;
    reg_write_dg  = valid_d_q & RegWriteD;
    mem_to_reg_dg = valid_d_q & MemtoRegD;
    pc_src_dg     = valid_d_q & PCSrcD;
    branch_dg     = valid_d_q & BranchD;
  end

  // Forward select for one E-stage operand; M beats W and R15 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       rw_m,
                                         input logic [3:0] wa_m,
                                         input logic       rw_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = FwdRf;
    if (ra != RegPc) begin
      if (rw_m && (ra == wa_m)) begin
        sel = FwdM;
      end else if (rw_w && (ra == wa_w)) begin
        sel = FwdW;
      end
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(ra1_e_q, reg_write_m_q, wa3_m_q, reg_write_w_q, wa3_w_q);
    ForwardBE = fwd_sel(ra2_e_q, reg_write_m_q, wa3_m_q, reg_write_w_q, wa3_w_q);
  end

  always_comb begin
    ldr_stall     = mem_to_reg_e_q & reg_write_e_q &
                    ((ra1_dg == wa3_e_q) | (ra2_dg == wa3_e_q));
    pc_wr_pending = pc_src_dg | pc_src_e_q | pc_src_m_q;
    BranchTakenE  = branch_e_q & CondExE;
    StallF        = ldr_stall | pc_wr_pending;
    StallD        = ldr_stall;
    FlushD        = pc_wr_pending | pc_src_w_q | BranchTakenE;
    FlushE        = ldr_stall | BranchTakenE;
  end

  // A flush beats a simultaneous stall, so the held D slot becomes a bubble.
  always_comb begin
    if (FlushD) begin
      valid_d_d = 1'b0;
    end else if (StallD) begin
      valid_d_d = valid_d_q;
    end else begin
      valid_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d_q <= 1'b0;
    end else begin
      valid_d_q <= valid_d_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra1_e_q        <= 4'h0;
      ra2_e_q        <= 4'h0;
      wa3_e_q        <= 4'h0;
      reg_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      pc_src_e_q     <= 1'b0;
      branch_e_q     <= 1'b0;
    end else if (FlushE) begin
      ra1_e_q        <= 4'h0;
      ra2_e_q        <= 4'h0;
      wa3_e_q        <= 4'h0;
      reg_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      pc_src_e_q     <= 1'b0;
      branch_e_q     <= 1'b0;
    end else begin
      ra1_e_q        <= ra1_dg;
      ra2_e_q        <= ra2_dg;
      wa3_e_q        <= wa3_dg;
      reg_write_e_q  <= reg_write_dg;
      mem_to_reg_e_q <= mem_to_reg_dg;
      pc_src_e_q     <= pc_src_dg;
      branch_e_q     <= branch_dg;
    end
  end

  // E->M and M->W never stall; a failed condition squashes the writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_m_q <= 1'b0;
      pc_src_m_q    <= 1'b0;
      wa3_m_q       <= 4'h0;
      reg_write_w_q <= 1'b0;
      pc_src_w_q    <= 1'b0;
      wa3_w_q       <= 4'h0;
    end else begin
      reg_write_m_q <= reg_write_e_q & CondExE;
      pc_src_m_q    <= pc_src_e_q & CondExE;
      wa3_m_q       <= wa3_e_q;
      reg_write_w_q <= reg_write_m_q;
      pc_src_w_q    <= pc_src_m_q;
      wa3_w_q       <= wa3_m_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PerfClear) begin
      stall_cnt_d = '0;
    end else if (StallD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (PerfClear) begin
      flush_cnt_d = '0;
    end else if (BranchTakenE && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: hand-derived per-cycle expectations are queued
// at drive time and compared at the following falling edge.
module tb_hazard_unit;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       m2r;
    logic       pcs;
    logic       br;
    logic       cex;
    logic       clr;
  } stim_t;

  // Expected control vector: {FA[1:0], FB[1:0], StallF, StallD, FlushD, FlushE, BrTaken}
  localparam logic [8:0] ExpNone  = 9'b000000000;
  localparam logic [8:0] ExpLdStl = 9'b000011010;
  localparam logic [8:0] ExpBrTkn = 9'b000000111;
  localparam logic [8:0] ExpLdBr  = 9'b000011111;
  localparam logic [8:0] ExpPcStl = 9'b000010100;
  localparam logic [8:0] ExpPcW   = 9'b000000100;
  localparam logic [8:0] ExpFwdMM = 9'b101000000;
  localparam logic [8:0] ExpFwdWW = 9'b010100000;
  localparam logic [8:0] ExpFbW   = 9'b000100000;

  logic       clk;
  logic       reset;
  logic [3:0] ra1_d, ra2_d, wa3_d;
  logic       reg_write_d, mem_to_reg_d, pc_src_d, branch_d, cond_ex_e, perf_clear;

  logic [1:0]  fa, fb;
  logic        stall_f, stall_d, flush_d, flush_e, br_taken;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_br_taken;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  string       tag_q[$];
  logic [44:0] exp_q[$];

  logic [15:0] sc_t = 16'h0, fc_t = 16'h0;
  logic [1:0]  scs_t = 2'h0, fcs_t = 2'h0;

  hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .RA1D        (ra1_d),
    .RA2D        (ra2_d),
    .WA3D        (wa3_d),
    .RegWriteD   (reg_write_d),
    .MemtoRegD   (mem_to_reg_d),
    .PCSrcD      (pc_src_d),
    .BranchD     (branch_d),
    .CondExE     (cond_ex_e),
    .PerfClear   (perf_clear),
    .ForwardAE   (fa),
    .ForwardBE   (fb),
    .StallF      (stall_f),
    .StallD      (stall_d),
    .FlushD      (flush_d),
    .FlushE      (flush_e),
    .BranchTakenE(br_taken),
    .StallCount  (stall_cnt),
    .FlushCount  (flush_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a short run
  hazard_unit #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .RA1D        (ra1_d),
    .RA2D        (ra2_d),
    .WA3D        (wa3_d),
    .RegWriteD   (reg_write_d),
    .MemtoRegD   (mem_to_reg_d),
    .PCSrcD      (pc_src_d),
    .BranchD     (branch_d),
    .CondExE     (cond_ex_e),
    .PerfClear   (perf_clear),
    .ForwardAE   (s_fa),
    .ForwardBE   (s_fb),
    .StallF      (s_stall_f),
    .StallD      (s_stall_d),
    .FlushD      (s_flush_d),
    .FlushE      (s_flush_e),
    .BranchTakenE(s_br_taken),
    .StallCount  (s_stall_cnt),
    .FlushCount  (s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic stim_t mk(input logic [3:0] ra1, input logic [3:0] ra2,
                               input logic [3:0] wa3, input logic rw, input logic m2r,
                               input logic pcs, input logic br, input logic cex,
                               input logic clr);
    stim_t s;
    s.ra1 = ra1; s.ra2 = ra2; s.wa3 = wa3;
    s.rw = rw; s.m2r = m2r; s.pcs = pcs; s.br = br; s.cex = cex; s.clr = clr;
    return s;
  endfunction

  // Drive one cycle of D/E inputs and queue what the outputs must be this cycle.
  task automatic cyc(input string tag, input stim_t s, input logic [8:0] e, input bit rst_mid);
    @(posedge clk);
    #1;
    ra1_d = s.ra1; ra2_d = s.ra2; wa3_d = s.wa3;
    reg_write_d = s.rw; mem_to_reg_d = s.m2r; pc_src_d = s.pcs; branch_d = s.br;
    cond_ex_e = s.cex; perf_clear = s.clr;
    if (rst_mid) begin
      sc_t = 16'h0; fc_t = 16'h0; scs_t = 2'h0; fcs_t = 2'h0;
    end
    tag_q.push_back(tag);
    exp_q.push_back({e, sc_t, fc_t, scs_t, fcs_t});
    if (!rst_mid && reset) begin
      if (s.clr) begin
        sc_t = 16'h0; fc_t = 16'h0; scs_t = 2'h0; fcs_t = 2'h0;
      end else begin
        if (e[3]) begin
          if (sc_t != 16'hFFFF) sc_t = sc_t + 16'h1;
          if (scs_t != 2'h3) scs_t = scs_t + 2'h1;
        end
        if (e[0]) begin
          if (fc_t != 16'hFFFF) fc_t = fc_t + 16'h1;
          if (fcs_t != 2'h3) fcs_t = fcs_t + 2'h1;
        end
      end
    end
    if (rst_mid) begin
      #2;
      reset = 1'b0;
    end
  endtask

  task automatic load_use(input string tag, input logic clr);
    cyc({tag, ".ld"},    mk(4'd0, 4'd0, 4'd3, 1, 1, 0, 0, 0, 0),   ExpNone,  0);
    cyc({tag, ".stall"}, mk(4'd0, 4'd3, 4'd4, 1, 0, 0, 0, 1, clr), ExpLdStl, 0);
    cyc({tag, ".held"},  mk(4'd0, 4'd3, 4'd4, 1, 0, 0, 0, 0, 0),   ExpNone,  0);
    cyc({tag, ".fwd"},   mk(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0),   ExpFbW,   0);
  endtask

  always @(negedge clk) begin : monitor
    string       t;
    logic [44:0] e;
    if (tag_q.size() != 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq({t, ".ctl"}, 32'({fa, fb, stall_f, stall_d, flush_d, flush_e, br_taken}),
               32'(e[44:36]));
      check_eq({t, ".stall_cnt"}, 32'(stall_cnt), 32'(e[35:20]));
      check_eq({t, ".flush_cnt"}, 32'(flush_cnt), 32'(e[19:4]));
      check_eq({t, ".n.ctl"}, 32'({s_fa, s_fb, s_stall_f, s_stall_d, s_flush_d, s_flush_e,
                                   s_br_taken}), 32'(e[44:36]));
      check_eq({t, ".n.stall_cnt"}, 32'(s_stall_cnt), 32'(e[3:2]));
      check_eq({t, ".n.flush_cnt"}, 32'(s_flush_cnt), 32'(e[1:0]));
    end
  end

  initial begin
    stim_t idle;
    stim_t idle_c;
    stim_t mov_pc;
    idle   = mk(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    idle_c = mk(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0);
    mov_pc = mk(4'd0, 4'd0, 4'd15, 1, 0, 1, 0, 0, 0);
    reset = 1'b0;
    ra1_d = 4'd0; ra2_d = 4'd0; wa3_d = 4'd0;
    reg_write_d = 1'b0; mem_to_reg_d = 1'b0; pc_src_d = 1'b0; branch_d = 1'b0;
    cond_ex_e = 1'b0; perf_clear = 1'b0;

    // Reset: busy inputs must not leak through while reset/ValidD are low
    cyc("rst0", mk(4'd5, 4'd5, 4'd5, 1, 1, 1, 1, 1, 0), ExpNone, 0);
    cyc("rst1", mk(4'd5, 4'd5, 4'd5, 1, 1, 1, 1, 1, 0), ExpNone, 0);
    reset = 1'b1;
    cyc("idle", idle, ExpNone, 0);

    // Forwarding priority, M over W, then W only
    cyc("fwd.sub",  mk(4'd0, 4'd0, 4'd2, 1, 0, 0, 0, 0, 0), ExpNone,  0);
    cyc("fwd.add",  mk(4'd0, 4'd0, 4'd2, 1, 0, 0, 0, 1, 0), ExpNone,  0);
    cyc("fwd.use",  mk(4'd2, 4'd2, 4'd0, 0, 0, 0, 0, 1, 0), ExpNone,  0);
    cyc("fwd.mw",   idle,                                   ExpFwdMM, 0);
    cyc("fwdw.sub", mk(4'd0, 4'd0, 4'd2, 1, 0, 0, 0, 0, 0), ExpNone,  0);
    cyc("fwdw.add", mk(4'd0, 4'd0, 4'd2, 1, 0, 0, 0, 1, 0), ExpNone,  0);
    cyc("fwdw.use", mk(4'd2, 4'd2, 4'd0, 0, 0, 0, 0, 0, 0), ExpNone,  0);
    cyc("fwdw.w",   idle,                                   ExpFwdWW, 0);

    // R15 is never forwarded
    cyc("r15.wr", mk(4'd0, 4'd0, 4'd15, 1, 0, 0, 0, 0, 0), ExpNone, 0);
    cyc("r15.rd", mk(4'd15, 4'd15, 4'd0, 0, 0, 0, 0, 1, 0), ExpNone, 0);
    cyc("r15.e",  idle,                                    ExpNone, 0);

    load_use("lu", 1'b0);

    // Taken and not-taken branch
    cyc("br.d",      mk(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0), ExpNone,  0);
    cyc("br.e",      idle_c,                                ExpBrTkn, 0);
    cyc("br.after",  idle,                                  ExpNone,  0);
    cyc("brn.d",     mk(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0), ExpNone,  0);
    cyc("brn.e",     idle,                                  ExpNone,  0);
    cyc("brn.after", idle,                                  ExpNone,  0);

    // Load-use and taken branch together; flush must win so the PCSrcD is dropped
    cyc("mix.d",     mk(4'd0, 4'd0, 4'd5, 1, 1, 0, 1, 0, 0), ExpNone, 0);
    cyc("mix.e",     mk(4'd5, 4'd0, 4'd0, 0, 0, 1, 0, 1, 0), ExpLdBr, 0);
    cyc("mix.gate",  mk(4'd5, 4'd0, 4'd0, 0, 0, 1, 0, 0, 0), ExpNone, 0);
    cyc("mix.after", idle,                                  ExpNone, 0);

    // PC write, condition passed then failed
    cyc("pc.d",    mov_pc, ExpPcStl, 0);
    cyc("pc.e",    idle_c, ExpPcStl, 0);
    cyc("pc.m",    idle,   ExpPcStl, 0);
    cyc("pc.w",    idle,   ExpPcW,   0);
    cyc("pc.done", idle,   ExpNone,  0);
    cyc("pcn.d",   mov_pc, ExpPcStl, 0);
    cyc("pcn.e",   idle,   ExpPcStl, 0);
    cyc("pcn.m",   idle,   ExpNone,  0);
    cyc("pcn.w",   idle,   ExpNone,  0);

    // PerfClear on a stall cycle, then drive the narrow counter into saturation
    load_use("clr", 1'b1);
    for (int i = 0; i < 4; i++) begin
      load_use($sformatf("sat%0d", i), 1'b0);
    end

    // Reset pulsed in the middle of a load-use stall
    cyc("rm.ld",    mk(4'd0, 4'd0, 4'd3, 1, 1, 0, 0, 0, 0), ExpNone, 0);
    cyc("rm.stall", mk(4'd0, 4'd3, 4'd4, 1, 0, 0, 0, 1, 0), ExpNone, 1);
    cyc("rm.hold",  mk(4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 0, 0), ExpNone, 0);
    reset = 1'b1;
    cyc("rm.go",    mov_pc, ExpPcStl, 0);
    cyc("rm.go2",   idle,   ExpPcStl, 0);
    cyc("rm.end",   idle,   ExpNone,  0);

    @(negedge clk);
    @(negedge clk);
    #1;
    if (tag_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", tag_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
